score_display_bcd: RTL
======================

SCORE_DISPLAY_BCD -- requirements
Module: score_display_bcd

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, number of decimal digits driven (legal 1..6).
REQ-002 SHALL have parameter SCORE_W, default 7, binary score width (legal 1..20).
REQ-003 SHALL have parameter BLANK_LZ, default 1; 1 = blank leading zeros, 0 = show them.
REQ-004 SHALL have parameter FLASH_CYCLES, default 0, length of flash-on-change window; 0 disables flashing.
REQ-005 SHALL have parameter FLASH_SHIFT, default 3, counter bit selecting flash phase.
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port score  input  SCORE_W  unsigned binary score to display.
REQ-009 SHALL have port score_valid  input  1  request to convert score.
REQ-010 SHALL have port ready  output  1  high only in IDLE; conversion accepted when score_valid && ready.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a new value is committed to the display.
REQ-012 SHALL have port overflow  output  1  committed score exceeds 10^NUM_DIGITS-1.
REQ-013 SHALL have port seg7  output  NUM_DIGITS x 7  active-low segments; index 0 = least-significant digit.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, COMMIT; IDLE->SHIFT on accept, SHIFT->COMMIT after SCORE_W shift cycles, COMMIT->IDLE unconditionally.
REQ-015 SHALL capture score on the accepting edge and convert it by serial double-dabble, one bit per SHIFT cycle (add 3 to any BCD nibble >= 5 before each shift).
REQ-016 SHALL update seg7, overflow and pulse done on the COMMIT edge, exactly SCORE_W+1 edges after the accepting edge.
REQ-017 SHALL ignore score_valid while ready is low, including in the COMMIT cycle; ready rises the cycle after COMMIT.
REQ-018 SHALL hold seg7 at the last committed value during SHIFT and COMMIT (no intermediate values visible).
REQ-019 SHALL encode digits 0-9 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; blank = 1111111; dash = 0111111.
REQ-020 SHALL, when BLANK_LZ=1, blank every digit above the most significant nonzero digit; digit 0 is never blanked.
REQ-021 SHALL, on overflow, drive dash on every digit and set overflow; overflow clears on the next in-range commit.
REQ-022 SHALL, when FLASH_CYCLES>0 and a commit changes the displayed value, load the flash counter with FLASH_CYCLES and decrement it each cycle to 0.
REQ-023 SHALL blank all digits while the flash counter is nonzero and its bit FLASH_SHIFT is 1; a commit of an unchanged value leaves the counter untouched.
REQ-024 SHALL, on a changed commit during an active flash, reload the counter with FLASH_CYCLES.

Reset
REQ-025 SHALL, on any edge with reset low, enter IDLE, abort any conversion, clear the flash counter, done=0, overflow=0.
REQ-026 SHALL reset seg7 to value 0: digit 0 = 1000000; others blank if BLANK_LZ=1, 1000000 otherwise.
REQ-027 SHALL drive ready=1 from the first edge after reset is released; a score_valid seen during reset is discarded.

Structure
REQ-028 SHALL place segment constants (SEG_0..SEG_9, SEG_BLANK, SEG_DASH) and the FSM state enum in package score_disp_pkg.
REQ-029 SHALL instantiate one sub-module, seg7_decode (4-bit BCD in, 7-bit active-low out, combinational), once per digit.

Verification (NUM_DIGITS=2, SCORE_W=7, BLANK_LZ=1 unless noted)
REQ-030 SHALL check: reset low, then score=42 valid at edge k -> ready low k+1..k+8, done at edge k+8, seg7[1]=0011001, seg7[0]=0100100.
REQ-031 SHALL check: score=7 -> seg7[1]=1111111, seg7[0]=1111000; with BLANK_LZ=0 -> seg7[1]=1000000.
REQ-032 SHALL check: score=100 -> both digits 0111111, overflow=1; then score=99 -> 0010000/0010000, overflow=0.
REQ-033 SHALL check: score=42 accepted, score=13 pulsed at edges k+3 and k+8 -> both ignored, display 42, single done pulse.
REQ-034 SHALL check: reset low at edge k+4 mid-conversion -> no done, seg7 = blank/1000000, ready=1 after release.
REQ-035 SHALL check: FLASH_CYCLES=32, FLASH_SHIFT=3, 5 then 6 committed -> digits blanked exactly while counter bit 3 is 1 for 32 cycles; recommitting 6 -> no flash.

Source files
------------

// File: rtl/score_disp_pkg.sv
// Shared constants for the BCD score display: segment patterns, FSM states
// and the double-dabble adjust step used by the serial converter.
package score_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Seven BCD digits hold any 20-bit score (max 1048575), so the converter
  // always has headroom above the displayed digits for overflow detection.
  localparam int BCD_DIGITS = 7;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Add 3 to every nibble >= 5 ahead of the next left shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_bcd_seg7_decode.sv
// One BCD digit to active-low seven-segment pattern; codes 10-15 show blank.
module seg7_decode
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup, no state.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_bcd.sv
// Binary score to multi-digit seven-segment display via serial double-dabble,
// with leading-zero blanking, overflow dashes and optional flash-on-change.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready high; waits for score_valid, captures score on accept
// ST_SHIFT  | one double-dabble shift per cycle, SCORE_W cycles
// ST_COMMIT | converted value goes to display regs, done pulses, back to idle
module score_display_bcd
  import score_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int SCORE_W      = 7,
  parameter int BLANK_LZ     = 1,
  parameter int FLASH_CYCLES = 0,
  parameter int FLASH_SHIFT  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SCORE_W-1:0]      score,
  input  logic                    score_valid,
  output logic                    ready,
  output logic                    done,
  output logic                    overflow,
  output logic [NUM_DIGITS*7-1:0] seg7
);

  localparam int CNT_W    = $clog2(SCORE_W + 1);
  localparam int FL_W_RAW = $clog2(FLASH_CYCLES + 1);
  // The counter must be wide enough both for the load value and the phase bit.
  localparam int FL_W     = (FL_W_RAW > FLASH_SHIFT + 1) ? FL_W_RAW : FLASH_SHIFT + 1;
  localparam int DISP_W   = 4 * NUM_DIGITS;

  state_e              state_q, state_d;
  logic [SCORE_W-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic [FL_W-1:0]     flash_q, flash_d;

  logic [BCD_W-1:0]    adj;
  logic [DISP_W-1:0]   new_digits;
  logic                new_ovf;
  logic                changed;
  logic                flash_blank;
  logic                upper_zero;
  logic [6:0]          dec_seg [NUM_DIGITS];

  assign new_digits = bcd_q[DISP_W-1:0];
  assign new_ovf    = |bcd_q[BCD_W-1:DISP_W];
  // Two overflowing values look identical (all dashes), so they are not a change.
  assign changed    = (new_ovf != ovf_q) || (!new_ovf && (new_digits != disp_q));
  assign adj        = dabble_adjust(bcd_q);

  // State register plus datapath flops; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      flash_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      flash_q <= flash_d;
    end
  end

  // Next-state, shift datapath, commit and flash down-counter.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    flash_d = (flash_q != '0) ? flash_q - FL_W'(1) : flash_q;

    case (state_q)
      ST_IDLE: begin
        if (score_valid) begin
          bin_d   = score;
          bcd_d   = '0;
          cnt_d   = CNT_W'(SCORE_W);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = (adj << 1) | BCD_W'(bin_q[SCORE_W-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        disp_d  = new_digits;
        ovf_d   = new_ovf;
        if ((FLASH_CYCLES > 0) && changed) begin
          flash_d = FL_W'(FLASH_CYCLES);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .bcd (disp_q[4*g +: 4]),
      .seg (dec_seg[g])
    );
  end

  assign flash_blank = (flash_q != '0) && flash_q[FLASH_SHIFT];

  // Output digits from the committed value: flash blank > dash > leading-zero blank.
  always_comb begin
    seg7       = '1;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_q[4*i +: 4] == 4'd0);
      if (flash_blank) begin
        seg7[7*i +: 7] = SEG_BLANK;
      end else if (ovf_q) begin
        seg7[7*i +: 7] = SEG_DASH;
      end else if ((BLANK_LZ != 0) && (i != 0) && upper_zero) begin
        seg7[7*i +: 7] = SEG_BLANK;
      end else begin
        seg7[7*i +: 7] = dec_seg[i];
      end
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
